adc_capture: RTL and testbench

ADC_CAPTURE -- requirements
Module: adc_capture

---
 rtl/adc_capture.sv | 132 +++++++++++++
 tb/tb_adc_capture.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture.sv
// Triggered ADC frame capture: divided conversion clock, synchronised trigger edge,
// and one FRAME_LEN-sample burst into a downstream ping-pong buffer.
module adc_capture #(
    parameter int DATA_WIDTH = 12,
    parameter int FRAME_LEN  = 1024,
    parameter int DIV_WIDTH  = 8,
    localparam int ADDR_WIDTH = $clog2(FRAME_LEN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIV_WIDTH-1:0]  div,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic                  signal_in,
    input  logic                  buf_free,
    output logic                  adc_clk,
    output logic                  ADC_OE,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  frame_done,
    output logic                  busy,
    output logic [7:0]            trig_miss
);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t                state_q, state_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d, div_q, div_d;
    logic                  adc_clk_q, adc_clk_d;
    logic                  sync1_q, sync1_d, sync2_q, sync2_d, edge_q, edge_d;
    logic [ADDR_WIDTH-1:0] sample_cnt_q, sample_cnt_d, wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  wr_en_q, wr_en_d;
    logic [7:0]            trig_miss_q, trig_miss_d;
    logic                  div_tick, fall_tick, trig, last_written;

    // >= rather than == so a smaller div loaded in IDLE cannot strand the counter above div_q
    assign div_tick     = (cnt_q >= div_q);
    assign fall_tick    = div_tick && adc_clk_q;
    assign trig         = sync2_q && !edge_q;
    assign last_written = wr_en_q && (wr_addr_q == ADDR_WIDTH'(FRAME_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (buf_free) state_d = ARMED;
            ARMED: begin
                if (trig)           state_d = CAPTURE;
                else if (!buf_free) state_d = IDLE;
            end
            CAPTURE: if (last_written) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == ARMED) || (state_q == CAPTURE);
        ADC_OE     = !busy;
        frame_done = (state_q == DONE);
    end

    always_comb begin
        cnt_d     = div_tick ? '0 : cnt_q + 1'b1;
        adc_clk_d = adc_clk_q ^ div_tick;
        div_d     = (state_q == IDLE) ? div : div_q;
        sync1_d   = signal_in;
        sync2_d   = sync1_q;
        edge_d    = sync2_q;

        trig_miss_d = trig_miss_q;
        if (state_q == IDLE && trig && !buf_free && trig_miss_q != 8'hFF)
            trig_miss_d = trig_miss_q + 1'b1;

        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        sample_cnt_d = '0;
        if (state_q == CAPTURE) begin
            sample_cnt_d = sample_cnt_q;
            if (fall_tick && !last_written) begin
                wr_en_d      = 1'b1;
                wr_addr_d    = sample_cnt_q;
                wr_data_d    = adc_data;
                sample_cnt_d = sample_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            div_q        <= '0;
            adc_clk_q    <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            edge_q       <= 1'b0;
            trig_miss_q  <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            sample_cnt_q <= '0;
        end else begin
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            adc_clk_q    <= adc_clk_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            edge_q       <= edge_d;
            trig_miss_q  <= trig_miss_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign adc_clk   = adc_clk_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign trig_miss = trig_miss_q;

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture: trigger/miss table plus hand-written frame,
// divider, re-trigger and mid-frame reset sequences.
module tb_adc_capture;

    localparam int DW = 12;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    div = 8'd0;
    logic [DW-1:0] adc_data = '0;
    logic          signal_in = 1'b0;
    logic          buf_free = 1'b0;
    logic          adc_clk, ADC_OE, wr_en, frame_done, busy;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [7:0]    trig_miss;

    adc_capture dut (
        .clk(clk), .rst_n(rst_n), .div(div), .adc_data(adc_data),
        .signal_in(signal_in), .buf_free(buf_free), .adc_clk(adc_clk),
        .ADC_OE(ADC_OE), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .busy(busy), .trig_miss(trig_miss)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Write-stream monitor state, cleared at the start of each frame
    int          cyc = 0, last_wr_cyc = 0, spacing = 2;
    int          wr_cnt = 0, exp_addr = 0, first_addr = -1;
    int          addr_err = 0, data_err = 0, spacing_err = 0;
    int          done_cnt = 0, overlap_err = 0, outside_err = 0;
    logic [DW-1:0] adc_at_edge = '0;

    // ADC model: output changes only while adc_clk is high
    always @(negedge clk) if (adc_clk === 1'b1) adc_data <= DW'($urandom);

    always @(posedge clk) adc_at_edge <= adc_data;

    always @(negedge clk) begin
        cyc++;
        if (wr_en === 1'b1) begin
            if (wr_data !== adc_at_edge) data_err++;
            if (int'(wr_addr) != exp_addr) addr_err++;
            if (wr_cnt > 0 && (cyc - last_wr_cyc) != spacing) spacing_err++;
            if (wr_cnt == 0) first_addr = int'(wr_addr);
            if (busy !== 1'b1) outside_err++;
            if (frame_done === 1'b1) overlap_err++;
            exp_addr    = int'(wr_addr) + 1;
            last_wr_cyc = cyc;
            wr_cnt++;
        end
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_trigger();
        signal_in = 1'b1;
        tick(3);
        signal_in = 1'b0;
        tick(3);
    endtask

    task automatic clear_mon(input int sp);
        spacing = sp; wr_cnt = 0; exp_addr = 0; first_addr = -1;
        addr_err = 0; data_err = 0; spacing_err = 0;
        done_cnt = 0; overlap_err = 0; outside_err = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_adc_clk"},    int'(adc_clk),    0);
        check({tag, "_ADC_OE"},     int'(ADC_OE),     1);
        check({tag, "_wr_en"},      int'(wr_en),      0);
        check({tag, "_wr_addr"},    int'(wr_addr),    0);
        check({tag, "_wr_data"},    int'(wr_data),    0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_busy"},       int'(busy),       0);
        check({tag, "_trig_miss"},  int'(trig_miss),  0);
    endtask

    task automatic wait_writes(input int n, input int limit, output bit ok);
        int i = 0;
        while (wr_cnt < n && i < limit) begin @(negedge clk); i++; end
        ok = (wr_cnt >= n);
    endtask

    task automatic wait_done(input int limit, output bit ok);
        int i = 0;
        while (done_cnt < 1 && i < limit) begin @(negedge clk); i++; end
        ok = (done_cnt >= 1);
    endtask

    // Counts clk cycles of one full high phase and the following low phase
    task automatic measure(output int hi, output int lo);
        int guard = 0;
        hi = 0; lo = 0;
        while (adc_clk !== 1'b0 && guard < 100) begin @(negedge clk); guard++; end
        while (adc_clk !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
        while (adc_clk === 1'b1 && guard < 100) begin hi++; @(negedge clk); guard++; end
        while (adc_clk === 1'b0 && guard < 100) begin lo++; @(negedge clk); guard++; end
    endtask

    typedef struct {
        logic buf_free;
        int   edges;
        int   exp_miss;
        logic exp_busy;
        logic exp_oe;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit ok;
        int hi, lo;

        vecs[0] = '{1'b0,   3,   3, 1'b0, 1'b1};
        vecs[1] = '{1'b0,   1,   4, 1'b0, 1'b1};
        vecs[2] = '{1'b1,   0,   4, 1'b1, 1'b0};
        vecs[3] = '{1'b0,   0,   4, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 296, 255, 1'b0, 1'b1};
        vecs[5] = '{1'b0,   2, 255, 1'b0, 1'b1};

        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(2);
        check_reset_outputs("post_release");

        clear_mon(2);
        for (int v = 0; v < 6; v++) begin
            buf_free = vecs[v].buf_free;
            tick(3);
            repeat (vecs[v].edges) pulse_trigger();
            tick(3);
            check($sformatf("vec%0d_trig_miss", v), int'(trig_miss), vecs[v].exp_miss);
            check($sformatf("vec%0d_busy", v),      int'(busy),      int'(vecs[v].exp_busy));
            check($sformatf("vec%0d_ADC_OE", v),    int'(ADC_OE),    int'(vecs[v].exp_oe));
        end
        check("miss_no_writes", wr_cnt, 0);

        // Full frame at div=0: adc_clk = clk/2, so one sample every 2 clk
        do_reset();
        check("reset_clears_miss", int'(trig_miss), 0);
        div = 8'd0;
        buf_free = 1'b1;
        clear_mon(2);
        tick(3);
        check("armed_busy", int'(busy), 1);
        check("armed_oe", int'(ADC_OE), 0);
        signal_in = 1'b1;
        wait_done(4000, ok);
        check("f0_done_seen", int'(ok), 1);
        tick(4);
        check("f0_wr_count", wr_cnt, 1024);
        check("f0_first_addr", first_addr, 0);
        check("f0_addr_err", addr_err, 0);
        check("f0_data_err", data_err, 0);
        check("f0_spacing_err", spacing_err, 0);
        check("f0_done_cycles", done_cnt, 1);
        check("f0_overlap", overlap_err, 0);
        check("f0_outside", outside_err, 0);

        // div=3 frame with div changed to 7 mid-capture
        buf_free = 1'b0;
        signal_in = 1'b0;
        tick(3);
        div = 8'd3;
        tick(3);
        clear_mon(8);
        buf_free = 1'b1;
        tick(3);
        signal_in = 1'b1;
        wait_writes(1, 100, ok);
        check("f1_started", int'(ok), 1);
        div = 8'd7;
        measure(hi, lo);
        check("div3_high", hi, 4);
        check("div3_low", lo, 4);
        wait_done(10000, ok);
        check("f1_done_seen", int'(ok), 1);
        tick(4);
        check("f1_wr_count", wr_cnt, 1024);
        check("f1_spacing_err", spacing_err, 0);
        check("f1_data_err", data_err, 0);
        buf_free = 1'b0;
        signal_in = 1'b0;
        tick(3);
        measure(hi, lo);
        check("div7_high", hi, 8);
        check("div7_low", lo, 8);

        // Trigger held high before arming must not start a capture
        do_reset();
        div = 8'd0;
        signal_in = 1'b1;
        tick(6);
        check("held_miss", int'(trig_miss), 1);
        buf_free = 1'b1;
        clear_mon(2);
        tick(20);
        check("held_armed", int'(busy), 1);
        check("held_no_write", wr_cnt, 0);
        signal_in = 1'b0;
        tick(4);
        signal_in = 1'b1;
        wait_writes(500, 2000, ok);
        check("f2_reach_500", int'(ok), 1);
        signal_in = 1'b0;
        tick(3);
        signal_in = 1'b1;
        wait_writes(600, 1000, ok);
        check("f2_reach_600", int'(ok), 1);
        buf_free = 1'b0;
        wait_done(2000, ok);
        check("f2_done_seen", int'(ok), 1);
        tick(4);
        check("f2_wr_count", wr_cnt, 1024);
        check("f2_addr_err", addr_err, 0);
        check("f2_done_cycles", done_cnt, 1);
        check("f2_miss_unchanged", int'(trig_miss), 1);
        check("f2_idle", int'(busy), 0);

        // Reset in the middle of a frame
        signal_in = 1'b0;
        buf_free = 1'b1;
        tick(4);
        clear_mon(2);
        signal_in = 1'b1;
        wait_writes(300, 1000, ok);
        check("f3_reach_300", int'(ok), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        signal_in = 1'b0;
        buf_free = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("midreset_no_done", done_cnt, 0);
        check("midreset_idle", int'(busy), 0);
        clear_mon(2);
        buf_free = 1'b1;
        tick(3);
        signal_in = 1'b1;
        wait_writes(1, 100, ok);
        check("f4_started", int'(ok), 1);
        check("f4_first_addr", first_addr, 0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
